// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Decodes the format and immediate of a raw RISC-V instruction word and
//   precomputes its branch/jump/AUIPC/LUI target address. The result is
//   registered behind a valid/ready handshake with a one-entry skid buffer.
//   in_ready depends only on registered state.
//
// Parameters
//   XLEN    datapath width, 32 or 64
//   PC_ADJ  constant subtracted from B/J immediates on out_imm only
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop every buffered entry and the entry offered this cycle
//   in_valid/in_ready     producer handshake for in_instr/in_pc
//   out_valid/out_ready   consumer handshake for out_* fields
//   out_imm               sign-extended immediate (shamt for shift-immediates)
//   out_target            pc+imm for B/J/AUIPC, imm for LUI, otherwise 0
//   out_fmt               0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   out_illegal           opcode not recognised
//   out_instr             instruction word passed through
module imm_decode_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_ADJ = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr
);

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam bit              IS64 = (XLEN == 64);
  localparam logic [XLEN-1:0] ADJ  = XLEN'(PC_ADJ);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
    logic [31:0]     instr;
  } entry_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_shamt5;
  logic [XLEN-1:0] w_shamt6;
  entry_t          w_dec;
  logic            w_accept;

  entry_t          r_out;
  entry_t          r_skid;
  logic            r_out_valid;
  logic            r_skid_valid;

  assign w_opcode   = in_instr[6:0];
  assign w_funct3   = in_instr[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  assign w_imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u  = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'h000};
  assign w_imm_j  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
  assign w_shamt5 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign w_shamt6 = {{(XLEN-6){1'b0}}, in_instr[25:20]};

  always_comb begin
    w_dec         = '0;
    w_dec.instr   = in_instr;
    w_dec.fmt     = FMT_ILL;
    w_dec.illegal = 1'b1;
    case (w_opcode)
      OPC_OP_IMM: begin
        w_dec.fmt     = FMT_I;
        w_dec.illegal = 1'b0;
        if (w_is_shift) w_dec.imm = IS64 ? w_shamt6 : w_shamt5;
        else            w_dec.imm = w_imm_i;
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        w_dec.fmt     = FMT_I;
        w_dec.illegal = 1'b0;
        w_dec.imm     = w_imm_i;
      end
      OPC_OP_IMM32: begin
        // Word shifts always carry a 5-bit shamt, even on a 64-bit datapath.
        if (IS64) begin
          w_dec.fmt     = FMT_I;
          w_dec.illegal = 1'b0;
          w_dec.imm     = w_is_shift ? w_shamt5 : w_imm_i;
        end
      end
      OPC_STORE: begin
        w_dec.fmt     = FMT_S;
        w_dec.illegal = 1'b0;
        w_dec.imm     = w_imm_s;
      end
      OPC_BRANCH: begin
        w_dec.fmt     = FMT_B;
        w_dec.illegal = 1'b0;
        w_dec.imm     = w_imm_b - ADJ;
        w_dec.target  = in_pc + w_imm_b;
      end
      OPC_LUI: begin
        w_dec.fmt     = FMT_U;
        w_dec.illegal = 1'b0;
        w_dec.imm     = w_imm_u;
        w_dec.target  = w_imm_u;
      end
      OPC_AUIPC: begin
        w_dec.fmt     = FMT_U;
        w_dec.illegal = 1'b0;
        w_dec.imm     = w_imm_u;
        w_dec.target  = in_pc + w_imm_u;
      end
      OPC_JAL: begin
        w_dec.fmt     = FMT_J;
        w_dec.illegal = 1'b0;
        w_dec.imm     = w_imm_j - ADJ;
        w_dec.target  = in_pc + w_imm_j;
      end
      OPC_OP: begin
        w_dec.fmt     = FMT_R;
        w_dec.illegal = 1'b0;
      end
      OPC_OP32: begin
        if (IS64) begin
          w_dec.fmt     = FMT_R;
          w_dec.illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // The skid is only ever filled while the output slot is held, so a free
  // skid is sufficient for acceptance.
  assign w_accept = in_valid && !r_skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      // Output slot frees up this edge: the older skid entry has priority.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out        <= w_dec;
        r_out_valid  <= 1'b1;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready    = !r_skid_valid;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out.imm;
  assign out_target  = r_out.target;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.illegal;
  assign out_instr   = r_out.instr;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage (XLEN=32, PC_ADJ=4).
module tb_imm_decode_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PC_ADJ = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_target;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [31:0] out_instr;

  int checks;
  int failures;

  imm_decode_stage #(.XLEN(XLEN), .PC_ADJ(PC_ADJ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_target  (out_target),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .out_instr   (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] target;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] instr;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] target;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  // Reference decode: immediates rebuilt with signed arithmetic on the whole word.
  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] s;
    logic [31:0] ii, is, ib, iu, ij;
    s  = instr;
    ii = 32'(s >>> 20);
    is = 32'((s >>> 25) <<< 5) | 32'(instr[11:7]);
    ib = 32'((s >>> 31) <<< 12) | (32'(instr[7]) << 11) | (32'(instr[30:25]) << 5)
         | (32'(instr[11:8]) << 1);
    iu = instr & 32'hFFFF_F000;
    ij = 32'((s >>> 31) <<< 20) | (32'(instr[19:12]) << 12) | (32'(instr[20]) << 11)
         | (32'(instr[30:21]) << 1);
    e       = '0;
    e.instr = instr;
    e.fmt   = 3'd7;
    e.ill   = 1'b1;
    case (instr[6:0])
      7'h13: begin
        e.fmt = 3'd1; e.ill = 1'b0;
        if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) e.imm = 32'(instr[24:20]);
        else e.imm = ii;
      end
      7'h03, 7'h67, 7'h73: begin e.fmt = 3'd1; e.ill = 1'b0; e.imm = ii; end
      7'h23: begin e.fmt = 3'd2; e.ill = 1'b0; e.imm = is; end
      7'h63: begin e.fmt = 3'd3; e.ill = 1'b0; e.imm = ib - PC_ADJ; e.target = pc + ib; end
      7'h37: begin e.fmt = 3'd4; e.ill = 1'b0; e.imm = iu; e.target = iu; end
      7'h17: begin e.fmt = 3'd4; e.ill = 1'b0; e.imm = iu; e.target = pc + iu; end
      7'h6F: begin e.fmt = 3'd5; e.ill = 1'b0; e.imm = ij - PC_ADJ; e.target = pc + ij; end
      7'h33: begin e.fmt = 3'd0; e.ill = 1'b0; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    checks++;
    if ({out_imm, out_target, out_fmt, out_illegal, out_instr} !== 100'd0) begin
      failures++;
      $display("FAIL reset_fields got imm=%h tgt=%h fmt=%0d ill=%b instr=%h exp all 0",
               out_imm, out_target, out_fmt, out_illegal, out_instr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    vec_t v [10] = '{
      '{32'hFFC12083, 32'h100, 32'hFFFFFFFC, 32'h0,   3'd1, 1'b0},  // lw -4
      '{32'hFE112E23, 32'h100, 32'hFFFFFFFC, 32'h0,   3'd2, 1'b0},  // sw -4
      '{32'h123452B7, 32'h100, 32'h12345000, 32'h12345000, 3'd4, 1'b0}, // lui
      '{32'h0080006F, 32'h100, 32'h4,        32'h108, 3'd5, 1'b0},  // jal +8
      '{32'h00000000, 32'h100, 32'h0,        32'h0,   3'd7, 1'b1},  // illegal
      '{32'h00001097, 32'h200, 32'h1000,     32'h1200, 3'd4, 1'b0}, // auipc
      '{32'h01F09093, 32'h0,   32'h1F,       32'h0,   3'd1, 1'b0},  // slli 31
      '{32'h41F0D093, 32'h0,   32'h1F,       32'h0,   3'd1, 1'b0},  // srai 31
      '{32'hFE000EE3, 32'h100, 32'hFFFFFFF8, 32'hFC,  3'd3, 1'b0},  // beq -4
      '{32'h0000109B, 32'h0,   32'h0,        32'h0,   3'd7, 1'b1}   // OP-IMM-32 on RV32
    };
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = v[i].instr; in_pc = v[i].pc; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_instr = $urandom();
      checks++;
      if (out_valid !== 1'b1 || out_imm !== v[i].imm || out_target !== v[i].target ||
          out_fmt !== v[i].fmt || out_illegal !== v[i].ill || out_instr !== v[i].instr) begin
        failures++;
        $display("FAIL vector%0d got v=%b imm=%h tgt=%h fmt=%0d ill=%b instr=%h exp v=1 imm=%h tgt=%h fmt=%0d ill=%b instr=%h",
                 i, out_valid, out_imm, out_target, out_fmt, out_illegal, out_instr,
                 v[i].imm, v[i].target, v[i].fmt, v[i].ill, v[i].instr);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL vector_drain got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    exp_t a, b, c;
    a = ref_decode(32'hFFC12083, 32'h100);
    b = ref_decode(32'hFE112E23, 32'h104);
    c = ref_decode(32'h123452B7, 32'h108);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = a.instr; in_pc = 32'h100;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || {out_imm, out_target, out_fmt, out_illegal, out_instr} !== a) begin
      failures++;
      $display("FAIL b2b_A ready=%b instr=%h exp ready=1 instr=%h", in_ready, out_instr, a.instr);
    end
    in_instr = b.instr; in_pc = 32'h104;
    @(negedge clk);
    in_instr = c.instr; in_pc = 32'h108;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {out_imm, out_target, out_fmt, out_illegal, out_instr} !== a) begin
        failures++;
        $display("FAIL b2b_stall%0d ready=%b valid=%b instr=%h imm=%h exp ready=0 valid=1 instr=%h imm=%h",
                 k, in_ready, out_valid, out_instr, out_imm, a.instr, a.imm);
      end
      if (k < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 ||
        {out_imm, out_target, out_fmt, out_illegal, out_instr} !== b) begin
      failures++;
      $display("FAIL b2b_B ready=%b valid=%b instr=%h exp ready=1 valid=1 instr=%h",
               in_ready, out_valid, out_instr, b.instr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 ||
        {out_imm, out_target, out_fmt, out_illegal, out_instr} !== c) begin
      failures++;
      $display("FAIL b2b_C ready=%b valid=%b instr=%h exp ready=1 valid=1 instr=%h",
               in_ready, out_valid, out_instr, c.instr);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h0;
    @(negedge clk);
    in_instr = 32'h00100093;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_full got ready=%b valid=%b exp ready=0 valid=1", in_ready, out_valid);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_two got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    // One entry held, and a new entry offered while flush is high must be dropped.
    in_valid = 1'b1; in_instr = 32'h00200113;
    @(negedge clk);
    in_instr = 32'h00300193; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_drop got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_after got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFC12083; in_pc = 32'h40;
    @(negedge clk);
    in_instr = 32'h0080006F;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_full got ready=%b valid=%b exp ready=0 valid=1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 || out_instr !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_async got valid=%b ready=%b imm=%h instr=%h exp valid=0 ready=1 imm=0 instr=0",
               out_valid, in_ready, out_imm, out_instr);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after%0d got valid=%b exp 0", k, out_valid);
      end
    end
  endtask

  task automatic test_random;
    exp_t q[$];
    exp_t e;
    logic [31:0] r;
    logic [6:0]  ops [14] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h00, 7'h7F};
    int unsigned sel;
    bit acc, con;
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rand_hs cyc=%0d got valid=%b ready=%b exp valid=%b ready=%b",
                 cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        checks++;
        if ({out_imm, out_target, out_fmt, out_illegal, out_instr} !== q[0]) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got imm=%h tgt=%h fmt=%0d ill=%b instr=%h exp imm=%h tgt=%h fmt=%0d ill=%b instr=%h",
                   cyc, out_imm, out_target, out_fmt, out_illegal, out_instr,
                   q[0].imm, q[0].target, q[0].fmt, q[0].ill, q[0].instr);
        end
      end
      r   = $urandom();
      sel = $urandom_range(0, 15);
      in_instr  = (sel < 14) ? {r[31:7], ops[sel]} : r;
      in_pc     = $urandom();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      flush     = ($urandom_range(0, 59) == 0);
      if (flush) begin
        q.delete();
      end else begin
        acc = in_valid && (q.size() < 2);
        con = (q.size() > 0) && out_ready;
        if (con) e = q.pop_front();
        if (acc) q.push_back(ref_decode(in_instr, in_pc));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter PC_ADJ, default 0, constant subtracted from B/J immediates on out_imm only.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  discard all buffered entries.
REQ-006 in_valid  input  1  producer offers in_instr/in_pc.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_instr  input  32  raw RV instruction word.
REQ-009 in_pc  input  XLEN  PC of in_instr.
REQ-010 out_valid  output  1  out_* fields hold a decoded entry.
REQ-011 out_ready  input  1  consumer takes entry this cycle.
REQ-012 out_imm  output  XLEN  sign-extended immediate.
REQ-013 out_target  output  XLEN  precomputed address.
REQ-014 out_fmt  output  3  0=R,1=I,2=S,3=B,4=U,5=J,7=illegal.
REQ-015 out_illegal  output  1  opcode not recognised.
REQ-016 out_instr  output  32  instruction passed through unchanged.

Function
REQ-017 Decode: I = 0010011, 0000011, 1100111, 1110011, and 0011011 only when XLEN=64; S = 0100011; B = 1100011; U = 0110111, 0010111; J = 1101111; R = 0110011, and 0111011 only when XLEN=64; every other opcode is illegal.
REQ-018 Immediates are fully sign-extended from instr[31] to XLEN for I, S, B, J, U, including loads and stores (no zero-extension).
REQ-019 Shift-immediates (OP-IMM funct3 001/101; XLEN=64 also opcode 0011011) give out_imm = shamt zero-extended: instr[24:20] for XLEN=32 or opcode 0011011, instr[25:20] otherwise.
REQ-020 B/J: out_imm = decoded immediate minus PC_ADJ (modulo 2^XLEN); R and illegal: out_imm = 0.
REQ-021 out_target = in_pc + decoded immediate (no PC_ADJ) for B, J and AUIPC; immediate for LUI; 0 otherwise; addition wraps modulo 2^XLEN.
REQ-022 Latency exactly 1 cycle: an entry accepted at edge N is visible on out_* after edge N if the output slot is free.
REQ-023 Storage: output register plus one skid register (2 entries max); strict FIFO order.
REQ-024 Accept on in_valid && in_ready; transfer on out_valid && out_ready.
REQ-025 in_ready = !skid_valid, registered-state only, no combinational path from out_ready.
REQ-026 Consumer stall with occupied output slot: next accepted entry goes to skid; on release the skid moves to output the same edge the output is consumed.
REQ-027 Simultaneous accept and consume with empty skid: new entry replaces output directly, skid stays empty.
REQ-028 out_* fields stable while out_valid && !out_ready.
REQ-029 flush: at next edge both entries invalidated; an entry offered in the flush cycle is dropped; out_valid = 0 and in_ready = 1 after that edge.
REQ-030 All fields sampled in the accept cycle; input changes after acceptance have no effect.

Reset
REQ-031 rst_n low immediately (asynchronously) clears out_valid and skid_valid; in_ready = 1 while in reset.
REQ-032 Reset values: out_imm, out_target, out_instr = 0; out_fmt = 0; out_illegal = 0.
REQ-033 Reset asserted mid-transfer loses all buffered entries; no entry emitted after deassertion without a new accept.

Verification
REQ-034 XLEN=32, PC_ADJ=0, in_instr 0xFFC12083 (lw), pc 0x100 -> next cycle out_imm 0xFFFFFFFC, out_fmt 1, out_target 0, out_illegal 0.
REQ-035 in_instr 0xFE112E23 (sw) -> out_imm 0xFFFFFFFC, out_fmt 2; in_instr 0x123452B7 (lui) -> out_imm and out_target 0x12345000, out_fmt 4.
REQ-036 PC_ADJ=4, in_instr 0x0080006F (jal +8), pc 0x100 -> out_imm 0x4, out_target 0x108, out_fmt 5.
REQ-037 out_ready=0, offer A,B,C back-to-back -> A,B accepted, in_ready 0 from the cycle after B; out_ready=1 -> A,B,C emitted in order, one per cycle, A's fields stable throughout stall.
REQ-038 in_instr 0x00000000 -> out_fmt 7, out_illegal 1, out_imm 0; flush with two buffered entries -> out_valid 0, in_ready 1 next cycle; rst_n pulse mid-stall clears both without a clock edge.
